// File: rtl/lsu_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_if
// Brief    : M-stage load/store unit driving a req/gnt/rvalid data-memory bus
// Revision : 1.0
// ============================================================================
module lsu_mem_if #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWriteM,
  input  logic                  MemReadM,
  input  logic [2:0]            funct3M,
  input  logic [ADDR_WIDTH-1:0] AddrM,
  input  logic [31:0]           WriteDataM,
  output logic [31:0]           ReadData,
  output logic                  StallMem,
  output logic                  MisalignM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                state_q;
  logic [31:0]           rdata_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [3:0]            mem_be_q;
  logic [31:0]           mem_wdata_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;

  logic        acc;
  logic        f3_ok;
  logic        misal;
  logic        legal;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign acc = MemWriteM | MemReadM;

  // A simultaneous read+write strobe is treated as a store, so store rules win.
  always_comb begin
    f3_ok = 1'b0;
    if (MemWriteM) begin
      f3_ok = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010);
    end else begin
      f3_ok = !((funct3M == 3'b011) || (funct3M == 3'b110) || (funct3M == 3'b111));
    end
  end

  assign misal = ((funct3M[1:0] == 2'b01) && AddrM[0]) ||
                 ((funct3M[1:0] == 2'b10) && (AddrM[1:0] != 2'b00));
  assign legal = f3_ok && !misal;

  always_comb begin
    be_d    = 4'b0000;
    wdata_d = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        be_d    = 4'b0001 << AddrM[1:0];
        wdata_d = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_d    = AddrM[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{WriteDataM[15:0]}};
      end
      2'b10: begin
        be_d    = 4'b1111;
        wdata_d = WriteDataM;
      end
      default: begin
        be_d    = 4'b0000;
        wdata_d = WriteDataM;
      end
    endcase
  end

  assign ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_ext = mem_rdata;
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc && legal) begin
            state_q     <= REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= MemWriteM;
            mem_addr_q  <= {AddrM[ADDR_WIDTH-1:2], 2'b00};
            mem_be_q    <= be_d;
            mem_wdata_q <= wdata_d;
            f3_q        <= funct3M;
            off_q       <= AddrM[1:0];
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              rdata_q <= '0;
              state_q <= DONE;
            end else begin
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          if (mem_rvalid) begin
            rdata_q <= ld_ext;
            state_q <= DONE;
          end
        end
        // M-stage inputs already belong to the next instruction once IDLE is re-entered.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign StallMem  = ((state_q == IDLE) && acc && legal) ||
                     (state_q == REQ) || (state_q == RESP);
  assign MisalignM = (state_q == IDLE) && acc && !legal;
  assign ReadData  = (state_q == DONE) ? rdata_q : 32'd0;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_if
// Brief    : Directed self-checking bench for lsu_mem_if
// Revision : 1.0
// ============================================================================
module tb_lsu_mem_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemReadM;
  logic [2:0]  funct3M;
  logic [31:0] AddrM, WriteDataM;
  logic [31:0] ReadData;
  logic        StallMem, MisalignM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_mem_if #(.ADDR_WIDTH(32)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .funct3M    (funct3M),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .ReadData   (ReadData),
    .StallMem   (StallMem),
    .MisalignM  (MisalignM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    MemWriteM  = 1'b0;
    MemReadM   = 1'b0;
    funct3M    = 3'b000;
    AddrM      = 32'd0;
    WriteDataM = 32'd0;
  endtask

  // One complete access; gdly = REQ cycles before gnt, rdly = RESP cycles before rvalid.
  task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int gdly, input int rdly, input logic [31:0] rword,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd);
    @(negedge clk);
    MemWriteM  = we;
    MemReadM   = ~we;
    funct3M    = f3;
    AddrM      = addr;
    WriteDataM = wd;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    check_eq({tag, ".idle_stall"}, 32'(StallMem), 32'd1);
    check_eq({tag, ".idle_mis"},   32'(MisalignM), 32'd0);
    check_eq({tag, ".idle_req"},   32'(mem_req), 32'd0);
    for (int i = 0; i <= gdly; i++) begin
      @(negedge clk);
      #1;
      check_eq({tag, ".req"},   32'(mem_req), 32'd1);
      check_eq({tag, ".we"},    32'(mem_we), 32'(we));
      check_eq({tag, ".addr"},  mem_addr, {addr[31:2], 2'b00});
      check_eq({tag, ".be"},    32'(mem_be), 32'(exp_be));
      check_eq({tag, ".wdata"}, mem_wdata, exp_wd);
      check_eq({tag, ".req_stall"}, 32'(StallMem), 32'd1);
      check_eq({tag, ".req_rd"}, ReadData, 32'd0);
      mem_gnt = (i == gdly);
    end
    if (!we) begin
      for (int j = 0; j <= rdly; j++) begin
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check_eq({tag, ".resp_req"},   32'(mem_req), 32'd0);
        check_eq({tag, ".resp_stall"}, 32'(StallMem), 32'd1);
        check_eq({tag, ".resp_rd"},    ReadData, 32'd0);
        mem_rvalid = (j == rdly);
        mem_rdata  = rword;
      end
    end
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h5A5A_5A5A;
    #1;
    check_eq({tag, ".done_stall"}, 32'(StallMem), 32'd0);
    check_eq({tag, ".done_req"},   32'(mem_req), 32'd0);
    check_eq({tag, ".done_rd"},    ReadData, exp_rd);
    @(negedge clk);
    idle_inputs();
    #1;
    check_eq({tag, ".after_rd"},    ReadData, 32'd0);
    check_eq({tag, ".after_req"},   32'(mem_req), 32'd0);
    check_eq({tag, ".after_stall"}, 32'(StallMem), 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst.req",   32'(mem_req), 32'd0);
    check_eq("rst.addr",  mem_addr, 32'd0);
    check_eq("rst.be",    32'(mem_be), 32'd0);
    check_eq("rst.wdata", mem_wdata, 32'd0);
    check_eq("rst.rd",    ReadData, 32'd0);
    check_eq("rst.stall", 32'(StallMem), 32'd0);
    reset = 1'b1;

    do_access("sw",  1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'd0, 4'b1111, 32'hDEADBEEF, 32'd0);
    do_access("sb",  1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'd0, 4'b1000, 32'hA5A5A5A5, 32'd0);
    do_access("sh",  1'b1, 3'b001, 32'h102, 32'h00001234, 1, 0, 32'd0, 4'b1100, 32'h12341234, 32'd0);
    do_access("lb",  1'b0, 3'b000, 32'h101, 32'd0, 0, 0, 32'h000080FF, 4'b0010, 32'd0, 32'hFFFFFF80);
    do_access("lbu", 1'b0, 3'b100, 32'h101, 32'd0, 0, 0, 32'h000080FF, 4'b0010, 32'd0, 32'h00000080);
    do_access("lhu", 1'b0, 3'b101, 32'h102, 32'd0, 0, 0, 32'hBEEF0000, 4'b1100, 32'd0, 32'h0000BEEF);
    do_access("lh",  1'b0, 3'b001, 32'h102, 32'd0, 0, 0, 32'h8001FFFF, 4'b1100, 32'd0, 32'hFFFF8001);
    do_access("lw",  1'b0, 3'b010, 32'h200, 32'd0, 3, 1, 32'hCAFEF00D, 4'b1111, 32'd0, 32'hCAFEF00D);

    // Misaligned halfword load: rejected, never requested.
    @(negedge clk);
    MemReadM = 1'b1;
    funct3M  = 3'b001;
    AddrM    = 32'h201;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("mis.flag",  32'(MisalignM), 32'd1);
      check_eq("mis.stall", 32'(StallMem), 32'd0);
      check_eq("mis.rd",    ReadData, 32'd0);
      @(negedge clk);
      check_eq("mis.req",   32'(mem_req), 32'd0);
    end
    // Illegal store funct3 at an aligned address.
    MemReadM  = 1'b0;
    MemWriteM = 1'b1;
    funct3M   = 3'b011;
    AddrM     = 32'h300;
    #1;
    check_eq("ill.flag",  32'(MisalignM), 32'd1);
    check_eq("ill.stall", 32'(StallMem), 32'd0);
    @(negedge clk);
    check_eq("ill.req",   32'(mem_req), 32'd0);
    idle_inputs();

    // Reset while waiting for a load response.
    @(negedge clk);
    MemReadM = 1'b1;
    funct3M  = 3'b010;
    AddrM    = 32'h300;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    check_eq("rr.resp_stall", 32'(StallMem), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    #1;
    check_eq("rr.req",   32'(mem_req), 32'd0);
    check_eq("rr.rd",    ReadData, 32'd0);
    check_eq("rr.stall", 32'(StallMem), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    check_eq("rr.late_rd",  ReadData, 32'd0);
    check_eq("rr.late_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    #1;
    check_eq("rr.late_rd2", ReadData, 32'd0);
    do_access("lw2", 1'b0, 3'b010, 32'h304, 32'd0, 0, 0, 32'h0BADF00D, 4'b1111, 32'd0, 32'h0BADF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
Load/store unit between the pipeline memory stage and a handshaked data-memory bus.
- Accepts the M-stage access: address, store data, funct3, read/write strobes.
- Generates byte enables and lane-replicated store data, and drives a req/gnt/rvalid bus.
- Aligns and sign/zero-extends load data into ReadData.
- Holds the pipeline via StallMem while a bus transaction is outstanding.

Parameters:
ADDR_WIDTH, 32, width of AddrM and mem_addr.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset (low = reset).
MemWriteM  input  1  M-stage store request.
MemReadM  input  1  M-stage load request.
funct3M  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
AddrM  input  ADDR_WIDTH  byte address (ALU result).
WriteDataM  input  32  store data, right-aligned.
ReadData  output  32  aligned/extended load result for the writeback register.
StallMem  output  1  pipeline hold request; combinational.
MisalignM  output  1  access rejected (misaligned or illegal funct3); combinational.
mem_req  output  1  bus request.
mem_we  output  1  1 = write.
mem_addr  output  ADDR_WIDTH  word-aligned address; bits [1:0] forced to 00.
mem_be  output  4  byte enables.
mem_wdata  output  32  lane-placed store data.
mem_gnt  input  1  bus accepts request this cycle.
mem_rvalid  input  1  read data valid; never in the same cycle as the gnt for that read.
mem_rdata  input  32  read word.

Behaviour:
- States: IDLE, REQ, RESP, DONE. On reset low at a clock edge:
  - state goes to IDLE;
  - captured-data register rdata_q goes to 0;
  - all registered bus outputs go to 0.
  - Mid-transaction reset drops mem_req next cycle and discards any pending response.
- Access: acc = MemWriteM | MemReadM. If both are set, the access is treated as a store.
- Illegal conditions:
  - Halfword with AddrM[0]=1, or word with AddrM[1:0]!=00.
  - Store funct3 not in {000,001,010}; load funct3 in {011,110,111}.
  - For an illegal access in IDLE: MisalignM=1, no request is issued, StallMem=0, ReadData=0.
- IDLE:
  - acc legal: StallMem=1. Next cycle: REQ, with mem_addr/mem_we/mem_be/mem_wdata registered from the inputs.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req=1; addr/we/be/wdata stay stable until gnt. StallMem=1.
  - On mem_gnt: store → DONE; load → RESP. mem_req drops the cycle after gnt.
- RESP:
  - StallMem=1; wait for mem_rvalid.
  - On rvalid: rdata_q <= extended lane data; go to DONE.
- DONE:
  - StallMem=0 and ReadData=rdata_q (0 for stores) for exactly one cycle; the pipeline advances on this edge.
  - Next state IDLE. IDLE does not re-issue in the same cycle it is entered from DONE, because the M-stage inputs then belong to the next instruction.
- ReadData is 0 in every state except DONE.
- Store lanes, with o = AddrM[1:0]:
  - sb: be = 0001 << o; wdata = {4{WriteDataM[7:0]}}.
  - sh: be = AddrM[1] ? 1100 : 0011; wdata = {2{WriteDataM[15:0]}}.
  - sw: be = 1111; wdata = WriteDataM.
- Loads: mem_be follows the same rules as stores. The lane is selected by the captured offset.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Minimum latency with gnt in the first REQ cycle:
  - store: 3 cycles (IDLE, REQ, DONE);
  - load with rvalid the next cycle: 4 cycles.
- No timeout: an unanswered request stalls indefinitely.

Test Plan:
1. sw: AddrM=0x100, WriteDataM=0xDEADBEEF, gnt immediate → mem_addr=0x100, be=1111, wdata=0xDEADBEEF; StallMem high 2 cycles, low in DONE.
2. sb: AddrM=0x103, data=0x000000A5 → be=1000, wdata=0xA5A5A5A5. sh to 0x102 with data 0x1234 → be=1100, wdata=0x12341234.
3. lb at 0x101, rdata=0x0000_80FF → ReadData=0xFFFFFF80. lbu same → 0x00000080. lhu at 0x102, rdata=0xBEEF0000 → 0x0000BEEF.
4. lw at 0x200, gnt delayed 3 cycles, rvalid 2 cycles after gnt → addr/be stable throughout REQ; StallMem high until DONE; ReadData equals rdata for exactly one cycle, 0 after.
5. lh at 0x201 → MisalignM=1, mem_req never asserted, StallMem=0, ReadData=0.
6. Reset pulled low while in RESP → next cycle state IDLE, mem_req=0, ReadData=0; a late rvalid is ignored; a fresh lw after reset completes normally.
